// File: rtl/lm_sm_sequencer.sv
// Decode-stage micro-op sequencer: passes ordinary instructions through and
// expands LM/SM into one micro-op per set bit of the 8-bit register mask.
module lm_sm_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ir_in,
    input  logic [15:0] pc_in,
    input  logic        ir_valid,
    input  logic        stall_in,
    input  logic        flush,
    output logic        busy,
    output logic        uop_valid,
    output logic [15:0] uop_ir,
    output logic [15:0] uop_pc,
    output logic [2:0]  uop_reg,
    output logic [2:0]  uop_offset,
    output logic        uop_is_load,
    output logic        uop_xfer,
    output logic        uop_first,
    output logic        uop_last
);

    typedef enum logic {IDLE, SEQ} state_t;

    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    state_t      state_q, state_d;
    logic [7:0]  rem_q, rem_d;
    logic [2:0]  off_q, off_d;
    logic        valid_q, valid_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] pc_q, pc_d;
    logic [2:0]  reg_q, reg_d;
    logic        load_q, load_d;
    logic        xfer_q, xfer_d;
    logic        first_q, first_d;
    logic        last_q, last_d;

    logic [2:0]  bit_idx;
    logic        is_mem;

    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic found;
        lowest_set = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (m[i] && !found) begin
                lowest_set = 3'(i);
                found      = 1'b1;
            end
        end
    endfunction

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        off_d   = off_q;
        valid_d = valid_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        reg_d   = reg_q;
        load_d  = load_q;
        xfer_d  = xfer_q;
        first_d = first_q;
        last_d  = last_q;
        bit_idx = '0;
        is_mem  = (ir_in[15:12] == OP_LM) || (ir_in[15:12] == OP_SM);

        if (flush) begin
            valid_d = 1'b0;
            state_d = IDLE;
            rem_d   = '0;
            off_d   = '0;
        end else if (stall_in) begin
            // every register holds
        end else if (state_q == SEQ) begin
            bit_idx       = lowest_set(rem_q);
            rem_d[bit_idx] = 1'b0;
            ir_d[bit_idx]  = 1'b0;
            valid_d = 1'b1;
            reg_d   = bit_idx;
            off_d   = off_q + 3'd1;
            xfer_d  = 1'b1;
            first_d = 1'b0;
            last_d  = (rem_d == 8'h00);
            state_d = (rem_d == 8'h00) ? IDLE : SEQ;
        end else if (ir_valid) begin
            valid_d = 1'b1;
            ir_d    = ir_in;
            pc_d    = pc_in;
            off_d   = '0;
            first_d = 1'b1;
            reg_d   = '0;
            rem_d   = '0;
            last_d  = 1'b1;
            xfer_d  = 1'b0;
            load_d  = 1'b0;
            if (is_mem) begin
                load_d = (ir_in[15:12] == OP_LM);
                if (ir_in[7:0] != 8'h00) begin
                    bit_idx        = lowest_set(ir_in[7:0]);
                    rem_d          = ir_in[7:0];
                    rem_d[bit_idx] = 1'b0;
                    ir_d[bit_idx]  = 1'b0;
                    reg_d   = bit_idx;
                    xfer_d  = 1'b1;
                    last_d  = (rem_d == 8'h00);
                    state_d = (rem_d == 8'h00) ? IDLE : SEQ;
                end
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            off_q   <= '0;
            valid_q <= 1'b0;
            ir_q    <= '0;
            pc_q    <= '0;
            reg_q   <= '0;
            load_q  <= 1'b0;
            xfer_q  <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            off_q   <= off_d;
            valid_q <= valid_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            reg_q   <= reg_d;
            load_q  <= load_d;
            xfer_q  <= xfer_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign busy        = (state_q == SEQ);
    assign uop_valid   = valid_q;
    assign uop_ir      = ir_q;
    assign uop_pc      = pc_q;
    assign uop_reg     = reg_q;
    assign uop_offset  = off_q;
    assign uop_is_load = load_q;
    assign uop_xfer    = xfer_q;
    assign uop_first   = first_q;
    assign uop_last    = last_q;

endmodule
